// File: rtl/grad_arb_pkg.sv
// Shared types and width helpers for the gradient DRAM write arbiter.
package grad_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
   typedef enum logic {FL_RUN, FL_DRAIN} flush_state_t;

   // Index width for n requesters; never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_NUM_REQ = 4;
   localparam int DEFAULT_IDX_W   = idx_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/grad_rr_picker.sv
// Combinational round-robin picker: first set bit of valid at or after rr_ptr, wrapping.
module grad_rr_picker
   import grad_arb_pkg::*;
#(
   parameter  int NUM_REQ = DEFAULT_NUM_REQ,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               any_valid
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      grant     = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!any_valid && valid[idx]) begin
            grant     = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/grad_dram_arbiter.sv
// Round-robin burst arbiter sharing one DRAM write port, plus global flush sequencing.
// Build option: define GRAD_ARB_PRIO_EN to give requester 0 absolute priority at each pick.
module grad_dram_arbiter
   import grad_arb_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int ADDR_WIDTH  = 32,
   parameter  int VALUE_WIDTH = 32,
   parameter  int BURST_SIZE  = 4,
   localparam int IDX_W       = idx_width(NUM_REQ),
   localparam int CNT_W       = $clog2(BURST_SIZE + 1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value,
   input  logic [NUM_REQ-1:0]             req_idle,
   output logic                           dram_valid,
   input  logic                           dram_ready,
   output logic [ADDR_WIDTH-1:0]          dram_addr,
   output logic [VALUE_WIDTH-1:0]         dram_value,
   input  logic                           flush,
   output logic                           flush_out,
   output logic                           flush_done,
   output logic [IDX_W-1:0]               grant_id,
   output logic                           idle
);

   arb_state_t       arb_state, arb_next;
   flush_state_t     fl_state, fl_next;
   logic [IDX_W-1:0] rr_ptr, rr_pick, next_grant, rr_adv;
   logic [CNT_W-1:0] beat_cnt;
   logic             any_valid, grant_valid, beat, burst_end, drain_done, quiet, rr_update;

   grad_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (rr_pick),
      .any_valid (any_valid)
   );

`ifdef GRAD_ARB_PRIO_EN
   assign next_grant = req_valid[0] ? '0 : rr_pick;
   assign rr_update  = (grant_id != '0);
`else
   assign next_grant = rr_pick;
   assign rr_update  = 1'b1;
`endif

   assign grant_valid = req_valid[grant_id];
   assign beat        = (arb_state == ARB_BURST) && grant_valid && dram_ready;
   // A stalled beat never ends the burst; only a completed last beat or a dropped valid does.
   assign burst_end   = (arb_state == ARB_BURST) &&
                        (!grant_valid || (beat && beat_cnt == CNT_W'(BURST_SIZE - 1)));
   assign rr_adv      = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign quiet       = (req_valid == '0) && (&req_idle);
   assign drain_done  = (fl_state == FL_DRAIN) && (arb_state == ARB_IDLE) && quiet;

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         arb_state <= ARB_IDLE;
         fl_state  <= FL_RUN;
      end else begin
         arb_state <= arb_next;
         fl_state  <= fl_next;
      end
   end

   always_comb begin
      arb_next   = arb_state;
      fl_next    = fl_state;
      dram_valid = 1'b0;
      req_ready  = '0;
      case (arb_state)
         ARB_IDLE:  if (any_valid) arb_next = ARB_BURST;
         ARB_BURST: begin
            dram_valid          = grant_valid;
            req_ready[grant_id] = dram_ready;
            if (burst_end) arb_next = ARB_IDLE;
         end
      endcase
      case (fl_state)
         FL_RUN:   if (flush) fl_next = FL_DRAIN;
         FL_DRAIN: if (drain_done) fl_next = FL_RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr   <= '0;
         beat_cnt <= '0;
         grant_id <= '0;
      end else begin
         if (arb_state == ARB_IDLE && any_valid) begin
            grant_id <= next_grant;
            beat_cnt <= '0;
         end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (burst_end && rr_update) rr_ptr <= rr_adv;
      end
   end

   assign dram_addr  = req_addr[int'(grant_id) * ADDR_WIDTH +: ADDR_WIDTH];
   assign dram_value = req_value[int'(grant_id) * VALUE_WIDTH +: VALUE_WIDTH];
   assign flush_out  = (fl_state == FL_DRAIN);
   assign flush_done = drain_done;
   assign idle       = (arb_state == ARB_IDLE) && (fl_state == FL_RUN) && quiet;

endmodule
